// File: rtl/cmp_sort_ctrl.sv
// ----------------------------------------------------------------------------
// cmp_sort_ctrl
// Sequencing controller for a shared external W-bit magnitude comparator.
// Collects a burst of N unsigned words, bubble-sorts them into descending
// order with one external compare per cycle, then streams them out over a
// valid/ready handshake.
//
// Optional feature macro: SORT_SWAP_CNT_EN
//   When defined, adds the 8-bit output swap_cnt, which counts swaps made
//   during SORT. It is cleared on reset and on entry to LOAD, and holds its
//   value through OUT.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input word valid
//   in_data    in   input word [W-1:0]
//   in_ready   out  high in LOAD (an input word is accepted this cycle)
//   cmp_a      out  to comparator DataA
//   cmp_b      out  to comparator DataB
//   cmp_ageb   in   from comparator AGEB (1 when cmp_a >= cmp_b)
//   out_valid  out  sorted word valid
//   out_data   out  sorted word [W-1:0]
//   out_last   out  marks the N-th output word
//   out_ready  in   consumer accepts out_data
//   busy       out  high in every state except IDLE
//   swap_cnt   out  swap count [7:0] (SORT_SWAP_CNT_EN only)
// ----------------------------------------------------------------------------
module cmp_sort_ctrl #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic [W-1:0] cmp_a,
   output logic [W-1:0] cmp_b,
   input  logic         cmp_ageb,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy
`ifdef SORT_SWAP_CNT_EN
   ,
   output logic [7:0]   swap_cnt
`endif
);

   localparam int unsigned IW = $clog2(N);
   localparam logic [IW-1:0] LastIdx = IW'(N - 1);
   localparam logic [IW-1:0] LastCmp = IW'(N - 2);

   typedef enum logic [1:0] {StIdle, StLoad, StSort, StOut} state_e;

   state_e         r_state;
   state_e         w_state_nxt;

   logic [W-1:0]   r_buf [N];
   logic [IW-1:0]  r_wr_idx;
   logic [IW-1:0]  r_rd_idx;
   logic [IW-1:0]  r_p;
   logic [IW-1:0]  r_j;
   logic           r_swapped;
   logic [W-1:0]   r_cmp_a_hold;
   logic [W-1:0]   r_cmp_b_hold;

   logic [IW-1:0]  w_j1;
   logic           w_pass_end;
   logic           w_swap;
   logic           w_pass_swapped;
   logic           w_sort_done;

   assign w_j1           = r_j + IW'(1);
   assign w_pass_end     = (r_j == (LastCmp - r_p));
   assign w_swap         = (r_state == StSort) && !cmp_ageb;
   // Swap flag for the pass including the compare happening this cycle.
   assign w_pass_swapped = r_swapped || !cmp_ageb;
   assign w_sort_done    = (r_state == StSort) && w_pass_end &&
                           (!w_pass_swapped || (r_p == LastCmp));

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: w_state_nxt = StLoad;
         StLoad: begin
            if (in_valid && (r_wr_idx == LastIdx)) begin
               w_state_nxt = StSort;
            end
         end
         StSort: begin
            if (w_sort_done) begin
               w_state_nxt = StOut;
            end
         end
         StOut: begin
            if (out_ready && (r_rd_idx == LastIdx)) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: buffer, indices, pass bookkeeping, compare-operand hold
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) begin
            r_buf[i] <= '0;
         end
         r_wr_idx     <= '0;
         r_rd_idx     <= '0;
         r_p          <= '0;
         r_j          <= '0;
         r_swapped    <= 1'b0;
         r_cmp_a_hold <= '0;
         r_cmp_b_hold <= '0;
      end else begin
         unique case (r_state)
            StLoad: begin
               if (in_valid) begin
                  r_buf[r_wr_idx] <= in_data;
                  if (r_wr_idx == LastIdx) begin
                     r_wr_idx  <= '0;
                     r_p       <= '0;
                     r_j       <= '0;
                     r_swapped <= 1'b0;
                  end else begin
                     r_wr_idx <= r_wr_idx + IW'(1);
                  end
               end
            end
            StSort: begin
               // Keep the operands visible on cmp_a/cmp_b after SORT ends.
               r_cmp_a_hold <= r_buf[r_j];
               r_cmp_b_hold <= r_buf[w_j1];
               if (!cmp_ageb) begin
                  r_buf[r_j]  <= r_buf[w_j1];
                  r_buf[w_j1] <= r_buf[r_j];
               end
               if (w_pass_end) begin
                  if (w_sort_done) begin
                     r_rd_idx <= '0;
                  end else begin
                     r_p       <= r_p + IW'(1);
                     r_j       <= '0;
                     r_swapped <= 1'b0;
                  end
               end else begin
                  r_j       <= w_j1;
                  r_swapped <= w_pass_swapped;
               end
            end
            StOut: begin
               if (out_ready) begin
                  r_rd_idx <= (r_rd_idx == LastIdx) ? '0 : r_rd_idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SORT_SWAP_CNT_EN
   logic [7:0] r_swap_cnt;

   // IDLE always proceeds to LOAD, so clearing in IDLE clears on LOAD entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_swap_cnt <= '0;
      end else if (r_state == StIdle) begin
         r_swap_cnt <= '0;
      end else if (w_swap) begin
         r_swap_cnt <= r_swap_cnt + 8'd1;
      end
   end

   assign swap_cnt = r_swap_cnt;
`endif

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      busy      = (r_state != StIdle);
      cmp_a     = r_cmp_a_hold;
      cmp_b     = r_cmp_b_hold;
      unique case (r_state)
         StLoad: in_ready = 1'b1;
         StSort: begin
            cmp_a = r_buf[r_j];
            cmp_b = r_buf[w_j1];
         end
         StOut: begin
            out_valid = 1'b1;
            out_data  = r_buf[r_rd_idx];
            out_last  = (r_rd_idx == LastIdx);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
module tb_cmp_sort_ctrl;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic [W-1:0] cmp_a;
   logic [W-1:0] cmp_b;
   logic         cmp_ageb;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         out_ready;
   logic         busy;
`ifdef SORT_SWAP_CNT_EN
   logic [7:0]   swap_cnt;
`endif

   int checks = 0;
   int errors = 0;

   cmp_sort_ctrl #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .cmp_a     (cmp_a),
      .cmp_b     (cmp_b),
      .cmp_ageb  (cmp_ageb),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
`ifdef SORT_SWAP_CNT_EN
      ,
      .swap_cnt  (swap_cnt)
`endif
   );

   // External magnitude comparator.
   assign cmp_ageb = (cmp_a >= cmp_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0][W-1:0] in_w;
      logic [N-1:0][W-1:0] exp_w;
      int                  sort_cyc;
      int                  swaps;
      bit                  stall;
      bit                  gap;
      bit                  junk;
   } vec_t;

   vec_t tbl [5];

   function automatic vec_t mk(input logic [W-1:0] i0, i1, i2, i3,
                               input logic [W-1:0] e0, e1, e2, e3,
                               input int sc, input int sw,
                               input bit st, input bit gp, input bit jk);
      vec_t v;
      v.in_w[0] = i0; v.in_w[1] = i1; v.in_w[2] = i2; v.in_w[3] = i3;
      v.exp_w[0] = e0; v.exp_w[1] = e1; v.exp_w[2] = e2; v.exp_w[3] = e3;
      v.sort_cyc = sc;
      v.swaps    = sw;
      v.stall    = st;
      v.gap      = gp;
      v.junk     = jk;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("load_entry_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic feed(input vec_t v);
      for (int i = 0; i < N; i++) begin
         if (v.gap && (i == 1 || i == 3)) begin
            in_valid = 1'b0;
            repeat (i) begin
               @(negedge clk);
               chk("gap_ready", 32'(in_ready), 32'd1);
            end
         end
         chk("load_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = v.in_w[i];
         @(negedge clk);
      end
      in_valid = v.junk;
      in_data  = 8'hEE;
      chk("ready_drop", 32'(in_ready), 32'd0);
   endtask

   task automatic run_burst(input vec_t v);
      logic [3:0] pat;
      int sc;
      int k;
      int t;
      logic rdy;
      pat = 4'b1001;
      wait_ready();
      feed(v);
      sc = 0;
      while (busy && !out_valid && !in_ready && sc < 100) begin
         sc++;
         @(negedge clk);
      end
      chk("sort_cycles", 32'(sc), 32'(v.sort_cyc));
      k = 0;
      t = 0;
      while (k < N && t < 64) begin
         rdy = v.stall ? pat[t % 4] : 1'b1;
         out_ready = rdy;
         chk("out_valid", 32'(out_valid), 32'd1);
         chk("out_data", 32'(out_data), 32'(v.exp_w[k]));
         chk("out_last", 32'(out_last), (k == N - 1) ? 32'd1 : 32'd0);
         chk("out_in_ready", 32'(in_ready), 32'd0);
         if (rdy) k++;
         t++;
         @(negedge clk);
      end
      chk("transfers", 32'(k), 32'(N));
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
`ifdef SORT_SWAP_CNT_EN
      chk("swap_cnt", 32'(swap_cnt), 32'(v.swaps));
`endif
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_last"}, 32'(out_last), 32'd0);
      chk({tag, "_out_data"}, 32'(out_data), 32'd0);
      chk({tag, "_cmp_a"}, 32'(cmp_a), 32'd0);
      chk({tag, "_cmp_b"}, 32'(cmp_b), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef SORT_SWAP_CNT_EN
      chk({tag, "_swap_cnt"}, 32'(swap_cnt), 32'd0);
`endif
   endtask

   initial begin
      //          inputs                   expected                 sort swp stl gap jnk
      tbl[0] = mk(8'h19, 8'hB3, 8'hF4, 8'h70, 8'hF4, 8'hB3, 8'h70, 8'h19, 6, 4, 0, 0, 0);
      tbl[1] = mk(8'hF4, 8'hB3, 8'h70, 8'h19, 8'hF4, 8'hB3, 8'h70, 8'h19, 3, 0, 0, 0, 0);
      tbl[2] = mk(8'h83, 8'h83, 8'h5C, 8'h7E, 8'h83, 8'h83, 8'h7E, 8'h5C, 5, 1, 0, 0, 0);
      tbl[3] = mk(8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 6, 3, 1, 0, 0);
      tbl[4] = mk(8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h30, 8'h20, 8'h10, 6, 6, 0, 1, 1);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_burst(tbl[i]);
      end

      // Reset in the middle of SORT, then a fresh burst.
      wait_ready();
      feed(tbl[0]);
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_sort_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      run_burst(mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h03, 8'h02, 8'h01, 6, 6, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
